// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the timing, colour and
// frame-buffer blocks.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Level driven on hsync/vsync during the pulse.
  localparam logic SYNC_ON = 1'b0;

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register with a per-bit reset value; DEPTH=0 is a
// straight passthrough.
module sync_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++)
          stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan counter with registered decodes aligned to pos, plus a
// delayed copy of active/hsync/vsync to meet the registered colour.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = vga_timing_pkg::H_VIS,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_VIS    = vga_timing_pkg::V_VIS,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int POS_W    = 10,
  parameter int SYNC_DLY = 1
) (
  input  logic             clk25MHz,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic             active_d,
  output logic             hsync_d,
  output logic             vsync_d
);

  typedef logic [POS_W-1:0] pos_t;

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam bit CFG_OK = (H_TOT - 1 < (1 << POS_W))
                       && (V_TOT - 1 < (1 << POS_W));

  // Inclusive bounds keep every constant within H/V_TOT-1.
  localparam pos_t X_LAST = pos_t'(H_TOT - 1);
  localparam pos_t Y_LAST = pos_t'(V_TOT - 1);
  localparam pos_t X_VEND = pos_t'(H_VIS - 1);
  localparam pos_t Y_VEND = pos_t'(V_VIS - 1);
  localparam pos_t HS_BEG = pos_t'(H_VIS + H_FP);
  localparam pos_t HS_END = pos_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam pos_t VS_BEG = pos_t'(V_VIS + V_FP);
  localparam pos_t VS_END = pos_t'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic [2:0] DLY_RST = {1'b0, ~SYNC_ON, ~SYNC_ON};

  pos_t next_x;
  pos_t next_y;
  logic x_wrap;
  logic in_act;
  logic in_hs;
  logic in_vs;
  logic [2:0] dly_q;

  always_comb begin
    x_wrap = (pos_x == X_LAST);
    next_x = x_wrap ? '0 : pos_x + pos_t'(1);
    next_y = pos_y;
    if (x_wrap)
      next_y = (pos_y == Y_LAST) ? '0 : pos_y + pos_t'(1);
  end

  assign in_act = (next_x <= X_VEND) && (next_y <= Y_VEND);
  assign in_hs  = (next_x >= HS_BEG) && (next_x <= HS_END);
  assign in_vs  = (next_y >= VS_BEG) && (next_y <= VS_END);

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pos_x       <= X_LAST;
      pos_y       <= Y_LAST;
      active      <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      pos_x       <= next_x;
      pos_y       <= next_y;
      active      <= in_act;
      hsync       <= in_hs ? SYNC_ON : ~SYNC_ON;
      vsync       <= in_vs ? SYNC_ON : ~SYNC_ON;
      line_start  <= (next_x == '0);
      frame_start <= (next_x == '0) && (next_y == '0);
    end
  end

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DLY),
    .RST_VAL (DLY_RST)
  ) u_dly (
    .clk   (clk25MHz),
    .rst_n (rst_n),
    .en    (en),
    .d     ({active, hsync, vsync}),
    .q     (dly_q)
  );

  assign active_d = dly_q[2];
  assign hsync_d  = dly_q[1];
  assign vsync_d  = dly_q[0];

  cfg_ok_a: assert property (@(posedge clk25MHz) CFG_OK)
    else $error("vga_timing_gen: POS_W too small for H/V total");

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for line/stall checks, small
// raster instances with SYNC_DLY 0/1/2 for frame, delay and reset checks.
module tb_vga_timing_gen;

  localparam int SH_VIS = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
  localparam int SV_VIS = 4, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #20 clk = ~clk;

  logic [9:0] fx, fy;
  logic fa, fh, fv, fls, ffs, fad, fhd, fvd;

  logic [3:0] x0, y0, x1, y1, x2, y2;
  logic a0, h0, v0, ls0, fs0, ad0, hd0, vd0;
  logic a1, h1, v1, ls1, fs1, ad1, hd1, vd1;
  logic a2, h2, v2, ls2, fs2, ad2, hd2, vd2;

  vga_timing_gen #(.SYNC_DLY(1)) u_full (
    .clk25MHz(clk), .rst_n(rst_n), .en(en),
    .pos_x(fx), .pos_y(fy), .active(fa), .hsync(fh), .vsync(fv),
    .line_start(fls), .frame_start(ffs),
    .active_d(fad), .hsync_d(fhd), .vsync_d(fvd));

  vga_timing_gen #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .POS_W(4), .SYNC_DLY(0)
  ) u_s0 (
    .clk25MHz(clk), .rst_n(rst_n), .en(en),
    .pos_x(x0), .pos_y(y0), .active(a0), .hsync(h0), .vsync(v0),
    .line_start(ls0), .frame_start(fs0),
    .active_d(ad0), .hsync_d(hd0), .vsync_d(vd0));

  vga_timing_gen #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .POS_W(4), .SYNC_DLY(1)
  ) u_s1 (
    .clk25MHz(clk), .rst_n(rst_n), .en(en),
    .pos_x(x1), .pos_y(y1), .active(a1), .hsync(h1), .vsync(v1),
    .line_start(ls1), .frame_start(fs1),
    .active_d(ad1), .hsync_d(hd1), .vsync_d(vd1));

  vga_timing_gen #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .POS_W(4), .SYNC_DLY(2)
  ) u_s2 (
    .clk25MHz(clk), .rst_n(rst_n), .en(en),
    .pos_x(x2), .pos_y(y2), .active(a2), .hsync(h2), .vsync(v2),
    .line_start(ls2), .frame_start(fs2),
    .active_d(ad2), .hsync_d(hd2), .vsync_d(vd2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Small-raster reference: 16 x 8, visible 8x4, hs 10..12, vs 5..6.
  int mx, my;
  logic [2:0] mo, md1, md2;
  logic mls, mfs;

  function automatic logic [2:0] dec(input int x, input int y);
    logic a, h, v;
    a = (x < 8) && (y < 4);
    h = !(x >= 10 && x <= 12);
    v = !(y >= 5 && y <= 6);
    return {a, h, v};
  endfunction

  task automatic model_reset();
    mx = 15; my = 7;
    mo = 3'b011; md1 = 3'b011; md2 = 3'b011;
    mls = 1'b0; mfs = 1'b0;
  endtask

  task automatic model_step();
    md2 = md1;
    md1 = mo;
    if (mx == 15) begin
      mx = 0;
      my = (my == 7) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    mo  = dec(mx, my);
    mls = (mx == 0);
    mfs = (mx == 0) && (my == 0);
  endtask

  task automatic chk_small();
    logic [14:0] e;
    e = {4'(mx), 4'(my), mo, mls, mfs};
    chk("s0_out", 32'({x0, y0, a0, h0, v0, ls0, fs0}), 32'(e));
    chk("s1_out", 32'({x1, y1, a1, h1, v1, ls1, fs1}), 32'(e));
    chk("s2_out", 32'({x2, y2, a2, h2, v2, ls2, fs2}), 32'(e));
    chk("s0_dly", 32'({ad0, hd0, vd0}), 32'(mo));
    chk("s1_dly", 32'({ad1, hd1, vd1}), 32'(md1));
    chk("s2_dly", 32'({ad2, hd2, vd2}), 32'(md2));
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) model_step();
    chk_small();
  endtask

  function automatic logic [27:0] full_pack();
    return {fx, fy, fa, fh, fv, fls, ffs, fad, fhd, fvd};
  endfunction

  typedef struct {
    logic en;
    int   x;
    int   y;
    logic a, h, v, ls, fs, ad;
  } vec_t;

  vec_t tbl[5];
  localparam logic [27:0] FULL_RST = {10'd799, 10'd524, 8'b0110_0011};

  initial begin
    int act_cnt, hs_cnt, hs_first, hs_last, ybad, ls_cnt;
    int vs_cnt, vs_first, vs_last, fs_cnt, sa_cnt;
    logic [27:0] hold;

    tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("full_reset", 32'(full_pack()), 32'(FULL_RST));
    chk_small();

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].en);
      chk($sformatf("vec%0d", i), 32'(full_pack()),
          32'({10'(tbl[i].x), 10'(tbl[i].y), tbl[i].a, tbl[i].h,
               tbl[i].v, tbl[i].ls, tbl[i].fs, tbl[i].ad,
               1'b1, 1'b1}));
    end

    for (int i = 0; i < 1000 && fx != 10'd799; i++) step(1'b1);
    chk("reach_x799", 32'({fx, fy}), 32'({10'd799, 10'd0}));
    step(1'b1);
    chk("line_wrap", 32'({fx, fy, fls, ffs}), 32'({10'd0, 10'd1, 2'b10}));

    act_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    ybad = 0; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (fa) act_cnt++;
      if (fls) ls_cnt++;
      if (fy != 10'd1) ybad++;
      if (!fh) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(fx);
        hs_last = int'(fx);
      end
      step(1'b1);
    end
    chk("line_active", act_cnt, 640);
    chk("line_hs_len", hs_cnt, 96);
    chk("line_hs_beg", hs_first, 656);
    chk("line_hs_end", hs_last, 751);
    chk("line_y_hold", ybad, 0);
    chk("line_ls_cnt", ls_cnt, 1);
    chk("line_period", 32'({fx, fy, fls}), 32'({10'd0, 10'd2, 1'b1}));

    for (int i = 0; i < 1000 && fx != 10'd655; i++) step(1'b1);
    chk("reach_x655", 32'({fx, fh, fa}), 32'({10'd655, 1'b1, 1'b0}));
    hold = full_pack();
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk($sformatf("stall%0d", i), 32'(full_pack()), 32'(hold));
    end
    step(1'b1);
    chk("hs_fall", 32'({fx, fh, fhd}), 32'({10'd656, 1'b0, 1'b1}));
    step(1'b1);
    chk("hsd_fall", 32'({fx, fh, fhd}), 32'({10'd657, 1'b0, 1'b0}));

    for (int i = 0; i < 300 && !(x1 == 4'd15 && y1 == 4'd7); i++)
      step(1'b1);
    chk("s_reach_last", 32'({x1, y1}), 32'({4'd15, 4'd7}));
    step(1'b1);
    chk("s_frame_wrap", 32'({x1, y1, ls1, fs1}), 32'({8'd0, 2'b11}));
    vs_cnt = 0; vs_first = -1; vs_last = -1; fs_cnt = 0; sa_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (fs1) fs_cnt++;
      if (a1) sa_cnt++;
      if (!v1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(y1);
        vs_last = int'(y1);
      end
      step(1'b1);
    end
    chk("s_vs_len", vs_cnt, 32);
    chk("s_vs_beg", vs_first, 5);
    chk("s_vs_end", vs_last, 6);
    chk("s_fs_cnt", fs_cnt, 1);
    chk("s_act_cnt", sa_cnt, 32);
    chk("s_frame_period", 32'({x1, y1, fs1}), 32'({8'd0, 1'b1}));

    for (int i = 0; i < 300 && !(x1 == 4'd11 && y1 == 4'd5); i++)
      step(1'b1);
    chk("s_reach_mid", 32'({x1, y1, h1, v1}), 32'({4'd11, 4'd5, 2'b00}));
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s",
        32'({x1, y1, a1, h1, v1, ls1, fs1, ad1, hd1, vd1}),
        32'({4'd15, 4'd7, 8'b0110_0011}));
    chk("async_rst_f", 32'(full_pack()), 32'(FULL_RST));
    model_reset();
    chk_small();
    #4;
    rst_n = 1'b1;
    step(1'b1);
    chk("restart_s", 32'({x1, y1, fs1, h1, v1}), 32'({8'd0, 3'b111}));
    chk("restart_f", 32'({fx, fy, ffs}), 32'({20'd0, 1'b1}));
    for (int i = 0; i < 200; i++) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
